// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the byte-serial ALU front end: state encoding,
// command byte field positions and the bit order of the captured flags.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Command byte layout; bits [1:0] are reserved and ignored.
  localparam int CMD_ACC_BIT  = 7;
  localparam int CMD_CTRL_MSB = 6;
  localparam int CMD_CTRL_LSB = 4;
  localparam int CMD_CANT_MSB = 3;
  localparam int CMD_CANT_LSB = 2;

  // Bit positions inside out_flags.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Byte-serial front end for the 8-bit ALU-with-flags block. Collects a
// command byte plus operands, presents registered operands to the ALU,
// captures result/flags and returns them over a valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for the command byte
// GET_A  | waiting for operand A
// GET_B  | waiting for operand B (A may come from the accumulator)
// EXEC   | one cycle: ALU settles on registered operands, result captured
// RESP   | response held until out_ready; valid rises one cycle after capture
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       alu_cantidad,
  input  logic [7:0]       alu_resultado,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [1:0]       cant_q, cant_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Input side is open in the three collecting states; forced low while reset is held.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && (state_q == ST_IDLE || state_q == ST_GET_A || state_q == ST_GET_B)) begin
      in_ready = 1'b1;
    end
  end

  assign accept       = in_valid & in_ready;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_control  = ctrl_q;
  assign alu_cantidad = cant_q;
  assign out_data     = res_q;
  assign out_flags    = flags_q;
  assign out_valid    = valid_q;
  assign op_count     = cnt_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    cant_d  = cant_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    flags_d = flags_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ctrl_d = in_data[CMD_CTRL_MSB:CMD_CTRL_LSB];
          cant_d = in_data[CMD_CANT_MSB:CMD_CANT_LSB];
          if (ACC_EN && in_data[CMD_ACC_BIT]) begin
            a_d     = acc_q;
            state_d = ST_GET_B;
          end else begin
            state_d = ST_GET_A;
          end
        end
      end
      ST_GET_A: begin
        if (accept) begin
          a_d     = in_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (accept) begin
          b_d     = in_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_resultado;
        flags_d = pack_flags(alu_negative, alu_zero, alu_carry, alu_overflow);
        acc_d   = alu_resultado;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      cant_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cant_q  <= cant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
